// File: rtl/sinfonia_pkg.sv
// Shared definitions for the sinfonia memory-game core: FSM state codes and
// default parameter values.
package sinfonia_pkg;

  localparam int N_BOTOES_DEF = 7;
  localparam int PROF_MEM_DEF = 16;
  localparam int W_PONTOS_DEF = 8;
  localparam int W_ERROS_DEF  = 4;
  localparam int T_NOTA_DEF   = 500;
  localparam int T_JOGADA_DEF = 5000;

  // The numeric code of each state is also what db_estado shows.
  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    PREPARA    = 4'd1,
    TOCA       = 4'd2,
    PAUSA      = 4'd3,
    ESPERA     = 4'd4,
    REGISTRA   = 4'd5,
    COMPARA    = 4'd6,
    PROXIMA    = 4'd7,
    FIM_ACERTO = 4'd8,
    FIM_ERRO   = 4'd9
  } estado_t;

endpackage

// File: rtl/sinfonia_temporizador.sv
// Down-counting timer: zera loads T-1, enable counts down, fim marks the
// T-th enabled cycle after a load.
module sinfonia_temporizador #(
  parameter int T = 500,
  localparam int W = (T > 1) ? $clog2(T) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic enable,
  output logic fim
);

  logic [W-1:0] cnt;

  // Load on zera, otherwise count down and stop at terminal count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= W'(T - 1);
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign fim = enable && (cnt == '0);

endmodule

// File: rtl/sinfonia_nucleo_param.sv
// Memory-game core: plays a growing note sequence, then checks the player's
// button presses note by note, with an optional training mode that replays
// a failed round instead of ending the game.
//
//  state      | meaning
//  INICIAL    | idle after reset, waiting for a jogar edge
//  PREPARA    | game start, note counter cleared
//  TOCA       | playing note[nota] for T_NOTA cycles
//  PAUSA      | silence for T_NOTA cycles between notes
//  ESPERA     | waiting for a button press, T_JOGADA timeout
//  REGISTRA   | press (or timeout) captured
//  COMPARA    | jogada vs expected note
//  PROXIMA    | round complete, advance or finish
//  FIM_ACERTO | game won
//  FIM_ERRO   | game lost
module sinfonia_nucleo_param
  import sinfonia_pkg::*;
#(
  parameter int N_BOTOES = N_BOTOES_DEF,
  parameter int PROF_MEM = PROF_MEM_DEF,
  parameter int W_PONTOS = W_PONTOS_DEF,
  parameter int W_ERROS  = W_ERROS_DEF,
  parameter int T_NOTA   = T_NOTA_DEF,
  parameter int T_JOGADA = T_JOGADA_DEF,
  localparam int AW = (PROF_MEM > 1) ? $clog2(PROF_MEM) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                treinamento,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic [AW-1:0]       limite,
  output logic [AW-1:0]       mem_endereco,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic [N_BOTOES-1:0] nota_out,
  output logic [W_PONTOS-1:0] pontos,
  output logic [W_ERROS-1:0]  erros,
  output logic                acertou,
  output logic                errou,
  output logic                pronto,
  output logic [3:0]          db_estado
);

  estado_t               estado, estado_prox;
  logic                  jogar_ant, botao_ant;
  logic                  jogar_sobe, botao_or, botao_sobe;
  logic                  treino, expirou, acerto;
  logic [AW-1:0]         lim_reg, rodada, nota;
  logic [N_BOTOES-1:0]   jogada;
  logic                  zera_nota, en_nota, fim_nota;
  logic                  zera_jogada, en_jogada, fim_jogada;

  assign jogar_sobe = jogar & ~jogar_ant;
  assign botao_or   = |botoes;
  assign botao_sobe = botao_or & ~botao_ant;
  // A timeout never counts as correct, even if the memory holds zero.
  assign acerto     = !expirou && (jogada == mem_dado);

  // Timers restart whenever their state is (re)entered.
  assign en_nota     = (estado == TOCA) || (estado == PAUSA);
  assign zera_nota   = (estado_prox != estado) &&
                       ((estado_prox == TOCA) || (estado_prox == PAUSA));
  assign en_jogada   = (estado == ESPERA);
  assign zera_jogada = (estado_prox == ESPERA) && (estado != ESPERA);

  sinfonia_temporizador #(.T(T_NOTA)) u_tmr_nota (
    .clock  (clock),
    .reset  (reset),
    .zera   (zera_nota),
    .enable (en_nota),
    .fim    (fim_nota)
  );

  sinfonia_temporizador #(.T(T_JOGADA)) u_tmr_jogada (
    .clock  (clock),
    .reset  (reset),
    .zera   (zera_jogada),
    .enable (en_jogada),
    .fim    (fim_jogada)
  );

  // Next-state decode.
  always_comb begin
    estado_prox = estado;
    case (estado)
      INICIAL, FIM_ACERTO, FIM_ERRO: if (jogar_sobe) estado_prox = PREPARA;
      PREPARA:  estado_prox = TOCA;
      TOCA:     if (fim_nota) estado_prox = PAUSA;
      PAUSA:    if (fim_nota) estado_prox = (nota == rodada) ? ESPERA : TOCA;
      ESPERA:   if (botao_sobe || fim_jogada) estado_prox = REGISTRA;
      REGISTRA: estado_prox = COMPARA;
      COMPARA: begin
        if (acerto)      estado_prox = (nota < rodada) ? ESPERA : PROXIMA;
        else if (treino) estado_prox = TOCA;
        else             estado_prox = FIM_ERRO;
      end
      PROXIMA:  estado_prox = (rodada == lim_reg) ? FIM_ACERTO : TOCA;
      default:  estado_prox = INICIAL;
    endcase
  end

  // State register and edge-detector history; jogar history resets high so
  // a level held through reset release is not taken as a start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      jogar_ant <= 1'b1;
      botao_ant <= 1'b0;
    end else begin
      estado    <= estado_prox;
      jogar_ant <= jogar;
      botao_ant <= botao_or;
    end
  end

  // Game datapath: counters, captured press, score and error tally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      treino  <= 1'b0;
      expirou <= 1'b0;
      lim_reg <= '0;
      rodada  <= '0;
      nota    <= '0;
      jogada  <= '0;
      pontos  <= '0;
      erros   <= '0;
    end else begin
      case (estado)
        INICIAL, FIM_ACERTO, FIM_ERRO: begin
          if (jogar_sobe) begin
            treino  <= treinamento;
            lim_reg <= limite;
            rodada  <= '0;
            nota    <= '0;
            pontos  <= '0;
            erros   <= '0;
            expirou <= 1'b0;
          end
        end
        PREPARA: nota <= '0;
        PAUSA: begin
          if (fim_nota) nota <= (nota == rodada) ? '0 : nota + 1'b1;
        end
        ESPERA: begin
          if (botao_sobe) begin
            jogada  <= botoes;
            expirou <= 1'b0;
          end else if (fim_jogada) begin
            jogada  <= '0;
            expirou <= 1'b1;
          end
        end
        COMPARA: begin
          if (acerto) begin
            if (pontos != '1) pontos <= pontos + 1'b1;
            if (nota < rodada) nota <= nota + 1'b1;
          end else if (treino) begin
            if (erros != '1) erros <= erros + 1'b1;
            nota <= '0;
          end
        end
        PROXIMA: begin
          if (rodada != lim_reg) begin
            rodada <= rodada + 1'b1;
            nota   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_endereco = nota;
  assign nota_out     = (estado == TOCA) ? mem_dado : '0;
  assign acertou      = (estado == FIM_ACERTO);
  assign errou        = (estado == FIM_ERRO);
  assign pronto       = (estado == FIM_ACERTO) || (estado == FIM_ERRO);
  assign db_estado    = estado;

endmodule

// File: tb/tb_sinfonia_nucleo_param.sv
// Bench for sinfonia_nucleo_param: expected notes are queued when a game or
// replay is set up and popped as each note starts on nota_out.
module tb_sinfonia_nucleo_param;
  import sinfonia_pkg::*;

  localparam int NB = 7;
  localparam int AW = 4;
  localparam int TN = 3;
  localparam int TJ = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          jogar = 1'b1;
  logic          treinamento = 1'b0;
  logic [NB-1:0] botoes = '0;
  logic [AW-1:0] limite = '0;
  logic [AW-1:0] mem_endereco, mem_endereco_s;
  logic [NB-1:0] mem_dado, mem_dado_s;
  logic [NB-1:0] nota_out, nota_out_s;
  logic [7:0]    pontos;
  logic [1:0]    pontos_s;
  logic [3:0]    erros, erros_s;
  logic          acertou, errou, pronto, acertou_s, errou_s, pronto_s;
  logic [3:0]    db_estado, db_estado_s;

  logic [NB-1:0] mem [16];
  logic [NB-1:0] sb [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  assign mem_dado   = mem[mem_endereco];
  assign mem_dado_s = mem[mem_endereco_s];

  sinfonia_nucleo_param #(
    .N_BOTOES(NB), .PROF_MEM(16), .W_PONTOS(8), .W_ERROS(4),
    .T_NOTA(TN), .T_JOGADA(TJ)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .treinamento(treinamento),
    .botoes(botoes), .limite(limite), .mem_endereco(mem_endereco),
    .mem_dado(mem_dado), .nota_out(nota_out), .pontos(pontos), .erros(erros),
    .acertou(acertou), .errou(errou), .pronto(pronto), .db_estado(db_estado)
  );

  // Narrow-score copy in lockstep, used for saturation.
  sinfonia_nucleo_param #(
    .N_BOTOES(NB), .PROF_MEM(16), .W_PONTOS(2), .W_ERROS(4),
    .T_NOTA(TN), .T_JOGADA(TJ)
  ) dut_sat (
    .clock(clock), .reset(reset), .jogar(jogar), .treinamento(treinamento),
    .botoes(botoes), .limite(limite), .mem_endereco(mem_endereco_s),
    .mem_dado(mem_dado_s), .nota_out(nota_out_s), .pontos(pontos_s),
    .erros(erros_s), .acertou(acertou_s), .errou(errou_s), .pronto(pronto_s),
    .db_estado(db_estado_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_estado(input string tag, input estado_t code, input int budget);
    int k = 0;
    while (db_estado != code && k < budget) begin
      @(negedge clock);
      k++;
    end
    check(tag, int'(db_estado), int'(code));
  endtask

  task automatic push_round(input int r);
    for (int n = 0; n <= r; n++) sb.push_back(mem[n]);
  endtask

  task automatic start(input logic t, input logic [AW-1:0] lim);
    treinamento = t;
    limite      = lim;
    jogar       = 1'b0;
    @(negedge clock);
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    check("start_state", int'(db_estado), int'(PREPARA));
    check("start_pontos", int'(pontos), 0);
    check("start_erros", int'(erros), 0);
  endtask

  task automatic press(input string tag, input logic [NB-1:0] val);
    wait_estado({tag, "_espera"}, ESPERA, 200);
    botoes = val;
    @(negedge clock);
    botoes = '0;
  endtask

  // Note monitor: pops the expected note at every note start and checks
  // that each uninterrupted note lasts T_NOTA cycles.
  initial begin
    logic [NB-1:0] nota_prev = '0;
    int dur = 0;
    forever begin
      @(negedge clock);
      if (nota_out != '0 && nota_prev == '0) begin
        if (sb.size() == 0) check("note_extra", int'(nota_out), 0);
        else check("note", int'(nota_out), int'(sb.pop_front()));
      end
      if (nota_out != '0) dur++;
      else if (dur != 0) begin
        if (reset) check("note_len", dur, TN);
        dur = 0;
      end
      nota_prev = nota_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 7'h01;
    mem[1] = 7'h04;
    mem[2] = 7'h10;

    // Reset state, with jogar held high through release.
    repeat (3) @(negedge clock);
    check("rst_estado", int'(db_estado), 0);
    check("rst_nota", int'(nota_out), 0);
    check("rst_pontos", int'(pontos), 0);
    check("rst_erros", int'(erros), 0);
    check("rst_pronto", int'(pronto), 0);
    check("rst_end", int'(mem_endereco), 0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("held_jogar_idle", int'(db_estado), int'(INICIAL));

    // Full game, three rounds, all correct.
    push_round(0); push_round(1); push_round(2);
    start(1'b0, 4'd2);
    for (int r = 0; r <= 2; r++)
      for (int n = 0; n <= r; n++) press("full", mem[n]);
    wait_estado("full_fim", FIM_ACERTO, 100);
    check("full_acertou", int'(acertou), 1);
    check("full_errou", int'(errou), 0);
    check("full_pronto", int'(pronto), 1);
    check("full_pontos", int'(pontos), 6);
    check("sat_pontos", int'(pontos_s), 3);
    check("full_drained", sb.size(), 0);

    // Wrong note in round 1.
    push_round(0); push_round(1);
    start(1'b0, 4'd2);
    press("wrong", 7'h01);
    press("wrong", 7'h01);
    press("wrong", 7'h02);
    wait_estado("wrong_fim", FIM_ERRO, 20);
    check("wrong_errou", int'(errou), 1);
    check("wrong_acertou", int'(acertou), 0);
    check("wrong_pronto", int'(pronto), 1);
    check("wrong_pontos", int'(pontos), 2);
    check("wrong_drained", sb.size(), 0);

    // Two buttons at once are never correct.
    push_round(0);
    start(1'b0, 4'd2);
    press("multi", 7'h05);
    wait_estado("multi_fim", FIM_ERRO, 20);
    check("multi_pontos", int'(pontos), 0);

    // Training: timeout, then a wrong press, then the right one.
    push_round(0);
    start(1'b1, 4'd0);
    wait_estado("trein_espera", ESPERA, 100);
    push_round(0);
    wait_estado("trein_replay", TOCA, TJ + 20);
    check("trein_erros1", int'(erros), 1);
    check("trein_pontos", int'(pontos), 0);
    check("trein_pronto", int'(pronto), 0);
    push_round(0);
    press("trein_multi", 7'h05);
    wait_estado("trein_replay2", TOCA, 20);
    check("trein_erros2", int'(erros), 2);
    press("trein_ok", 7'h01);
    wait_estado("trein_fim", FIM_ACERTO, 20);
    check("trein_pontos_fim", int'(pontos), 1);
    check("trein_erros_fim", int'(erros), 2);
    check("trein_drained", sb.size(), 0);

    // Button held across ESPERA entry is not a press.
    push_round(0); push_round(1);
    start(1'b0, 4'd1);
    botoes = 7'h01;
    wait_estado("held_espera", ESPERA, 100);
    repeat (5) @(negedge clock);
    check("held_no_capture", int'(db_estado), int'(ESPERA));
    botoes = '0;
    @(negedge clock);
    press("held", 7'h01);
    press("held", 7'h01);
    press("held", 7'h04);
    wait_estado("held_fim", FIM_ACERTO, 20);
    check("held_pontos", int'(pontos), 3);

    // Reset in the middle of a note.
    push_round(0);
    start(1'b0, 4'd2);
    wait_estado("mid_toca", TOCA, 10);
    @(negedge clock);
    #1 reset = 1'b0;
    jogar = 1'b1;
    #1;
    check("mid_estado", int'(db_estado), 0);
    check("mid_nota", int'(nota_out), 0);
    check("mid_end", int'(mem_endereco), 0);
    check("mid_pronto", int'(pronto), 0);
    @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    repeat (6) @(negedge clock);
    check("mid_no_restart", int'(db_estado), int'(INICIAL));
    check("mid_nota_idle", int'(nota_out), 0);
    jogar = 1'b0;
    check("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
